// File: rtl/l2_mp_trace_pkg.sv
// Shared definitions for the L2 main-pipe trace drain: payload layout, beat
// numbering and the stored record format.
package l2_mp_trace_pkg;

    localparam int unsigned PAYLOAD_W = 45;
    localparam int unsigned BEATS     = 4;
    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

    // Payload bit offsets, LSB first
    localparam int unsigned META_WWAY_LSB   = 0;
    localparam int unsigned META_WVALID_LSB = 2;
    localparam int unsigned MSHR_ID_LSB     = 3;
    localparam int unsigned ALLOC_PTR_LSB   = 11;
    localparam int unsigned ALLOC_VALID_LSB = 19;
    localparam int unsigned DIR_WAY_LSB     = 20;
    localparam int unsigned DIR_HIT_LSB     = 22;
    localparam int unsigned SSET_LSB        = 23;
    localparam int unsigned TAG_LSB         = 30;
    localparam int unsigned OPCODE_LSB      = 38;
    localparam int unsigned CHANNEL_LSB     = 41;
    localparam int unsigned MSHR_TASK_LSB   = 44;

    typedef enum logic [1:0] {
        BEAT_STAMP_LO,
        BEAT_STAMP_HI,
        BEAT_PAYLOAD_LO,
        BEAT_TRAILER
    } beat_e;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    typedef struct packed {
        logic [7:0]           seq;
        logic [PAYLOAD_W-1:0] payload;
        logic [63:0]          stamp;
    } record_t;

endpackage

// File: rtl/l2_mp_trace_fifo.sv
// Generic synchronous FIFO with a combinational head read and an entry count.
module l2_mp_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_mp_trace_drain.sv
// Captures L2 main-pipe monitor records into a FIFO and drains each one as
// four 32-bit beats on a valid/ready port; overflowed records are counted.
module l2_mp_trace_drain
    import l2_mp_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter logic [7:0]  SYNC  = SYNC_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic [1:0]             data_metaWway,
    input  logic                   data_metaWvalid,
    input  logic [7:0]             data_mshrId,
    input  logic [7:0]             data_allocPtr,
    input  logic                   data_allocValid,
    input  logic [1:0]             data_dirWay,
    input  logic                   data_dirHit,
    input  logic [6:0]             data_sset,
    input  logic [7:0]             data_tag,
    input  logic [2:0]             data_opcode,
    input  logic [2:0]             data_channel,
    input  logic                   data_mshrTask,
    input  logic [63:0]            stamp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_last,
    output logic [15:0]            drop_cnt,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e         state;
    beat_e          beat;
    logic [7:0]     seq;
    record_t        wr_rec;
    record_t        head;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;
    logic           push;
    logic           hs;
    logic           pop;
    logic           remain;

    always_comb begin
        wr_rec       = '0;
        wr_rec.seq   = seq;
        wr_rec.stamp = stamp;
        wr_rec.payload[META_WWAY_LSB   +: 2] = data_metaWway;
        wr_rec.payload[META_WVALID_LSB]      = data_metaWvalid;
        wr_rec.payload[MSHR_ID_LSB     +: 8] = data_mshrId;
        wr_rec.payload[ALLOC_PTR_LSB   +: 8] = data_allocPtr;
        wr_rec.payload[ALLOC_VALID_LSB]      = data_allocValid;
        wr_rec.payload[DIR_WAY_LSB     +: 2] = data_dirWay;
        wr_rec.payload[DIR_HIT_LSB]          = data_dirHit;
        wr_rec.payload[SSET_LSB        +: 7] = data_sset;
        wr_rec.payload[TAG_LSB         +: 8] = data_tag;
        wr_rec.payload[OPCODE_LSB      +: 3] = data_opcode;
        wr_rec.payload[CHANNEL_LSB     +: 3] = data_channel;
        wr_rec.payload[MSHR_TASK_LSB]        = data_mshrTask;
    end

    assign push      = en && !full;
    assign hs        = out_valid && out_ready;
    assign pop       = hs && (beat == BEAT_TRAILER);
    // A push landing with the final-beat pop keeps the stream going without a bubble
    assign remain    = (count > CW'(1)) || push;
    assign occupancy = count;

    l2_mp_trace_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(record_t))
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(wr_rec),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= BEAT_STAMP_LO;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            seq       <= '0;
            drop_cnt  <= '0;
        end else begin
            if (en) begin
                seq <= seq + 1'b1;
                if (full && drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (!empty || push) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        beat      <= BEAT_STAMP_LO;
                        out_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (beat == BEAT_TRAILER) begin
                            beat     <= BEAT_STAMP_LO;
                            out_last <= 1'b0;
                            if (!remain) begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                            end
                        end else begin
                            beat     <= beat_e'(beat + 2'd1);
                            out_last <= (beat == BEAT_PAYLOAD_LO);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (beat)
                BEAT_STAMP_LO:   out_data = head.stamp[31:0];
                BEAT_STAMP_HI:   out_data = head.stamp[63:32];
                BEAT_PAYLOAD_LO: out_data = head.payload[31:0];
                BEAT_TRAILER:    out_data = {SYNC, head.seq, 3'b000, head.payload[PAYLOAD_W-1:32]};
                default:         out_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_mp_trace_drain.sv
// Randomised and directed checks of l2_mp_trace_drain against a queue-based
// model of the record stream.
module tb_l2_mp_trace_drain;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  data_metaWway = '0;
    logic        data_metaWvalid = 1'b0;
    logic [7:0]  data_mshrId = '0;
    logic [7:0]  data_allocPtr = '0;
    logic        data_allocValid = 1'b0;
    logic [1:0]  data_dirWay = '0;
    logic        data_dirHit = 1'b0;
    logic [6:0]  data_sset = '0;
    logic [7:0]  data_tag = '0;
    logic [2:0]  data_opcode = '0;
    logic [2:0]  data_channel = '0;
    logic        data_mshrTask = 1'b0;
    logic [63:0] stamp = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [15:0] drop_cnt;
    logic [3:0]  occupancy;

    int total = 0;
    int bad = 0;

    l2_mp_trace_drain #(.DEPTH(DEPTH), .SYNC(8'hA5)) dut (
        .clock(clock), .reset(reset), .en(en),
        .data_metaWway(data_metaWway), .data_metaWvalid(data_metaWvalid),
        .data_mshrId(data_mshrId), .data_allocPtr(data_allocPtr),
        .data_allocValid(data_allocValid), .data_dirWay(data_dirWay),
        .data_dirHit(data_dirHit), .data_sset(data_sset), .data_tag(data_tag),
        .data_opcode(data_opcode), .data_channel(data_channel),
        .data_mshrTask(data_mshrTask), .stamp(stamp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .drop_cnt(drop_cnt), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: committed entries {seq, payload, stamp}, position within head record
    typedef logic [116:0] ent_t;
    ent_t       q[$];
    int         beat_m = 0;
    logic [7:0] seq_m = '0;
    int         drops_m = 0;
    bit         armed = 0;
    bit         m_full, m_hs, m_pop, m_push;
    ent_t       m_ent;

    function automatic logic [44:0] payload_now();
        return {data_mshrTask, data_channel, data_opcode, data_tag, data_sset,
                data_dirHit, data_dirWay, data_allocValid, data_allocPtr,
                data_mshrId, data_metaWvalid, data_metaWway};
    endfunction

    function automatic logic [31:0] word_of(input ent_t e, input int b);
        case (b)
            0:       return e[31:0];
            1:       return e[63:32];
            2:       return e[95:64];
            default: return {8'hA5, e[116:109], 3'b000, e[108:96]};
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            beat_m  = 0;
            seq_m   = '0;
            drops_m = 0;
            armed   = 1;
        end else begin
            m_full = (q.size() == DEPTH);
            m_hs   = (q.size() != 0) && out_ready;
            m_pop  = m_hs && (beat_m == 3);
            m_push = en && !m_full;
            if (m_hs) beat_m = (beat_m + 1) % 4;
            if (en && m_full && drops_m < 65535) drops_m++;
            m_ent = {seq_m, payload_now(), stamp};
            if (en) seq_m = seq_m + 8'd1;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(m_ent);
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            chk("valid", 64'(out_valid), 64'(q.size() != 0));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("drop_cnt", 64'(drop_cnt), 64'(drops_m));
            if (q.size() != 0) begin
                chk("data", 64'(out_data), 64'(word_of(q[0], beat_m)));
                chk("last", 64'(out_last), 64'(beat_m == 3));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_fields();
        data_metaWway   = 2'($urandom);
        data_metaWvalid = 1'($urandom);
        data_mshrId     = 8'($urandom);
        data_allocPtr   = 8'($urandom);
        data_allocValid = 1'($urandom);
        data_dirWay     = 2'($urandom);
        data_dirHit     = 1'($urandom);
        data_sset       = 7'($urandom);
        data_tag        = 8'($urandom);
        data_opcode     = 3'($urandom);
        data_channel    = 3'($urandom);
        data_mshrTask   = 1'($urandom);
        stamp           = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Drain with ready high; returns the seq field of the last trailer beat seen
    task automatic drain(output logic [7:0] last_seq);
        bit done;
        done      = 0;
        last_seq  = 8'hEE;
        out_ready = 1'b1;
        en        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (out_valid && out_last) last_seq = out_data[23:16];
            if (occupancy == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        chk("drain_done", 64'(done), 64'd1);
    endtask

    logic [7:0] s;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_drop", 64'(drop_cnt), 64'd0);

        // Single record, hand-computed beats
        tick();
        data_sset = 7'h55; data_tag = 8'hC3; data_opcode = 3'd4;
        stamp = 64'h0000_0001_0000_0002;
        out_ready = 1'b1;
        en = 1'b1;
        tick();
        en = 1'b0;
        @(negedge clock);
        chk("single_b0_valid", 64'(out_valid), 64'd1);
        chk("single_b0", 64'(out_data), 64'h0000_0002);
        chk("single_b0_last", 64'(out_last), 64'd0);
        tick(); @(negedge clock);
        chk("single_b1", 64'(out_data), 64'h0000_0001);
        tick(); @(negedge clock);
        chk("single_b2", 64'(out_data), 64'hEA80_0000);
        chk("single_b2_last", 64'(out_last), 64'd0);
        tick(); @(negedge clock);
        chk("single_b3", 64'(out_data), 64'hA500_0130);
        chk("single_b3_last", 64'(out_last), 64'd1);
        tick(); @(negedge clock);
        chk("single_empty", 64'(occupancy), 64'd0);
        chk("single_idle", 64'(out_valid), 64'd0);

        // Backpressure mid beat 1
        tick();
        rand_fields();
        stamp = 64'h1234_5678_9ABC_DEF0;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_hold", 64'(out_data), 64'h1234_5678);
            chk("bp_valid", 64'(out_valid), 64'd1);
            tick();
        end
        drain(s);

        // Overflow: 10 records into 8 entries
        do_reset();
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            tick();
        end
        en = 1'b0;
        @(negedge clock);
        chk("ovf_occ", 64'(occupancy), 64'd8);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        drain(s);
        chk("ovf_last_seq", 64'(s), 64'd7);
        tick();
        rand_fields();
        en = 1'b1;
        tick();
        en = 1'b0;
        drain(s);
        chk("ovf_next_seq", 64'(s), 64'd10);

        // Full FIFO, push coinciding with final-beat pop
        do_reset();
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rand_fields();
            tick();
        end
        en = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        @(negedge clock);
        chk("fullpop_at_last", 64'(out_last), 64'd1);
        rand_fields();
        en = 1'b1;
        tick();
        en = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        chk("fullpop_occ", 64'(occupancy), 64'd7);
        chk("fullpop_drop", 64'(drop_cnt), 64'd1);
        drain(s);

        // Reset during beat 2 with three records queued
        do_reset();
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            tick();
        end
        en = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_occ", 64'(occupancy), 64'd0);
        chk("rst_mid_drop", 64'(drop_cnt), 64'd0);
        tick();
        rand_fields();
        en = 1'b1;
        tick();
        en = 1'b0;
        drain(s);
        chk("rst_mid_seq", 64'(s), 64'd0);

        // 257 accepted records: the last carries seq 0
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            rand_fields();
            en = 1'b1;
            tick();
            en = 1'b0;
            tick(); tick(); tick();
        end
        drain(s);
        chk("wrap_seq", 64'(s), 64'd0);
        chk("wrap_nodrop", 64'(drop_cnt), 64'd0);

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            en        = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 70));
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        drain(s);

        // Drop counter saturation
        do_reset();
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 65545; i++) tick();
        en = 1'b0;
        @(negedge clock);
        chk("sat_drop", 64'(drop_cnt), 64'hFFFF);
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        @(negedge clock);
        chk("sat_hold", 64'(drop_cnt), 64'hFFFF);
        drain(s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_mp_trace_drain.md
Name: l2_mp_trace_drain

Overview:
- Receiving end of the L2 main-pipe monitor-point record stream.
- Each cycle `en` is high, captures one record (main-pipe fields plus 64-bit stamp) into a FIFO.
- Serialises each stored record as four 32-bit beats on a valid/ready port toward the debug/host trace sink.
- Counts records lost to FIFO overflow.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2).
- SYNC, 8'hA5, marker byte in beat 3 of every record.

Ports:
- clock  input  1  sole clock
- reset  input  1  synchronous, active-high
- en  input  1  record present this cycle
- data_metaWway  input  2  meta write way
- data_metaWvalid  input  1  meta write valid
- data_mshrId  input  8  MSHR id
- data_allocPtr  input  8  MSHR alloc pointer
- data_allocValid  input  1  alloc valid
- data_dirWay  input  2  directory way
- data_dirHit  input  1  directory hit
- data_sset  input  7  set index
- data_tag  input  8  tag
- data_opcode  input  3  opcode
- data_channel  input  3  channel
- data_mshrTask  input  1  MSHR task flag
- stamp  input  64  cycle stamp
- out_valid  output  1  beat valid
- out_ready  input  1  sink ready
- out_data  output  32  beat payload
- out_last  output  1  high on beat 3
- drop_cnt  output  16  saturating overflow count
- occupancy  output  clog2(DEPTH)+1  entries held

Behaviour:
- Payload P[44:0], LSB first:
  - metaWway[1:0], metaWvalid[2], mshrId[10:3], allocPtr[18:11], allocValid[19]
  - dirWay[21:20], dirHit[22], sset[29:23], tag[37:30], opcode[40:38], channel[43:41], mshrTask[44]
- Stored entry is {seq[7:0], P, stamp}.
- seq is an 8-bit counter. It increments on every cycle with `en`, whether the record is accepted or dropped, and wraps 255->0. A host sees drops as seq gaps.
- Beat order:
  - beat0 = stamp[31:0]
  - beat1 = stamp[63:32]
  - beat2 = P[31:0]
  - beat3 = {SYNC, seq, 3'b0, P[44:32]}
- Push: accepted iff `en` and the FIFO is not full at the start of the cycle. A pop completing in the same cycle does not free space for that push.
- Drop: `en` while full increments drop_cnt, saturating at 16'hFFFF. seq still advances.
- Latency: a record accepted in cycle t can drive out_valid in cycle t+1 at the earliest. There is no combinational path from `en` to out_valid.
- Drain FSM: states IDLE and SEND; 2-bit beat counter.
  - IDLE -> SEND when FIFO non-empty; out_valid=1 and beat=0.
  - In SEND, a beat advances on out_valid && out_ready.
  - On the beat-3 handshake the head entry pops. Next state is SEND with beat=0 if further entries remain, otherwise IDLE.
  - Back-to-back records produce no bubble.
- Stability: while out_valid && !out_ready, out_data, out_last and the beat counter hold. out_valid never drops without a handshake.
- occupancy reflects committed entries. Simultaneous push and final-beat pop leaves it unchanged.
- Reset values: out_valid=0, out_data=0, out_last=0, drop_cnt=0, occupancy=0, seq=0, FSM=IDLE, pointers=0.
- Reset mid-record: the partial record is abandoned, all entries are discarded, and no beat is emitted in the cycle after reset.
- Reset has priority over `en` in the same cycle; that record is neither stored nor counted.

Decomposition:
- Package l2_mp_trace_pkg holds:
  - payload field offsets/widths and PAYLOAD_W=45
  - BEATS=4
  - default SYNC
  - beat-select enum
  - a packed record struct {seq, payload, stamp}
- One sub-module, l2_mp_trace_fifo: a generic synchronous FIFO (DEPTH, width) with full, empty and count.
- Packing, seq, drop counter and drain FSM stay in the top.

Test Plan:
- Single record:
  - Stimulus: en=1 for one cycle; stamp=64'h0000_0001_0000_0002, sset=7'h55, tag=8'hC3, opcode=3'd4, out_ready=1.
  - Response: out_valid from t+1; beats 0x00000002, 0x00000001, P[31:0], {A5,00,...}; out_last only on beat 3; occupancy returns to 0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles mid beat 1.
  - Response: out_data stays at stamp[63:32] and out_valid=1 throughout; the stream resumes at beat 2 when ready rises.
- Overflow:
  - Stimulus: out_ready=0; 10 consecutive en (DEPTH=8).
  - Response: occupancy=8, drop_cnt=2. After draining, seq values read 0..7; the next accepted record carries seq 10.
- Full with concurrent pop:
  - Stimulus: FIFO full; en coincides with the beat-3 handshake.
  - Response: record dropped, drop_cnt+1, occupancy=7.
- Reset mid-drain:
  - Stimulus: assert reset during beat 2 of a record with 3 queued.
  - Response: next cycle out_valid=0, occupancy=0, drop_cnt=0; a fresh record afterwards emits seq 0.
- Seq wrap and saturation:
  - 257 accepted records: the 257th shows seq 0.
  - Forced drop_cnt at 16'hFFFF: one further drop holds it at FFFF.
